// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops, plus iterative
// WIDTH-cycle unsigned multiply (shift-add) and divide (restoring).
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    always_comb begin
        shamt   = b[SW-1:0];
        alu_res = '0;
        case (op)
            3'b000:  alu_res = a + b;
            3'b001:  alu_res = a - b;
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b100:  alu_res = a >> shamt;
            3'b101:  alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // acc_lo holds the multiplier (mul) or the remaining dividend bits (div);
    // quotient/product-low bits shift in as those bits shift out.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi   = mul_sum[WIDTH:1];
        mul_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};

        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh[WIDTH-1:0] - opnd;
        if (div_sh >= {1'b0, opnd}) begin
            div_hi = div_diff;
            div_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi = div_sh[WIDTH-1:0];
            div_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            c      <= '0;
            c_hi   <= '0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op[2:1] == 2'b11) begin
                            state  <= op[0] ? DIV : MUL;
                            busy   <= 1'b1;
                            cnt    <= CW'(WIDTH);
                            acc_hi <= '0;
                            acc_lo <= a;
                            opnd   <= b;
                        end else begin
                            c    <= alu_res;
                            c_hi <= '0;
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        c     <= mul_lo;
                        c_hi  <= mul_hi;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DIV: begin
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        c     <= div_lo;
                        c_hi  <= div_hi;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, operation request, sampled only while busy=0.
REQ-005 The block SHALL have port op, input, 3, operation select: 000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra, 110 mulu, 111 divu.
REQ-006 The block SHALL have ports a and b, input, WIDTH, operands, sampled on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1, high while a multi-cycle operation is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking a new result.
REQ-009 The block SHALL have port c, output, WIDTH, the primary result: sum, difference, logic, shift, product low half, or quotient.
REQ-010 The block SHALL have port c_hi, output, WIDTH, the secondary result: product high half or remainder; 0 for single-cycle ops.

Function
REQ-011 The block SHALL accept a request on any rising edge with start=1 and busy=0, latching op, a and b on that edge.
REQ-012 Ops 000-101 SHALL complete on the accepting edge: c and c_hi registered, done=1 for the following cycle, busy stays 0.
REQ-013 Add and sub SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-014 The shift amount for srl/sra SHALL be b[log2(WIDTH)-1:0]; upper bits of b ignored; sra replicates a[WIDTH-1].
REQ-015 Mulu SHALL be an unsigned iterative shift-add producing the 2*WIDTH-bit product as {c_hi, c}.
REQ-016 Divu SHALL be unsigned iterative restoring division: c=quotient, c_hi=remainder.
REQ-017 Divide by zero SHALL yield c = all ones and c_hi = a, with no error flag and the normal latency.
REQ-018 The FSM SHALL have states IDLE, MUL and DIV; IDLE->MUL/DIV on an accepted op 110/111, MUL/DIV->IDLE when the iteration counter expires.
REQ-019 For mulu/divu accepted at edge k, busy SHALL be 1 from edge k to edge k+WIDTH, with results and done=1 updated at edge k+WIDTH; latency is exactly WIDTH cycles.
REQ-020 The iteration counter SHALL be log2(WIDTH)+1 bits wide and count exactly WIDTH iterations.
REQ-021 start while busy=1 SHALL be ignored: no queueing and no effect on the operation in flight.
REQ-022 start=1 in the cycle where done=1 and busy=0 SHALL be accepted, giving back-to-back operation.
REQ-023 c and c_hi SHALL hold their last completed values until the next completion; intermediate iteration state SHALL NOT be visible on c or c_hi.
REQ-024 done SHALL never be high for two consecutive cycles from a single request.
REQ-025 An op value sampled with start=0 SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force the state to IDLE, busy=0, done=0, c=0, c_hi=0 and the counter to 0.
REQ-027 Reset asserted during MUL/DIV SHALL abort the operation and produce no done pulse.
REQ-028 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-029 The bench SHALL cover, with WIDTH=32, add 0xFFFFFFFF+0x00000001 -> next cycle c=0x00000000, c_hi=0, done=1 for 1 cycle, busy=0.
REQ-030 The bench SHALL cover, with WIDTH=32, sra a=0x80000000, b=0x00000024 (shift 4) -> c=0xF8000000; srl with the same inputs -> c=0x08000000.
REQ-031 The bench SHALL cover, with WIDTH=32, mulu 0xFFFFFFFF*0xFFFFFFFF -> after exactly 32 cycles busy falls, c=0x00000001, c_hi=0xFFFFFFFE, done pulses once; a start issued at cycle 10 is ignored.
REQ-032 The bench SHALL cover, with WIDTH=32, divu 100/7 -> c=14, c_hi=2 at 32 cycles; divu 5/0 -> c=0xFFFFFFFF, c_hi=5.
REQ-033 The bench SHALL cover reset mid-divu: rst_n low at cycle 15 -> outputs 0 asynchronously, no done pulse; a fresh add after release completes normally.
REQ-034 The bench SHALL cover, with WIDTH=8, mulu 0xFF*0x02 -> c=0xFE, c_hi=0x01 after 8 cycles, followed immediately by a back-to-back sub 0x00-0x01 -> c=0xFF one cycle later.
